// File: rtl/pipe_pkg.sv
// Shared types for the hazard/tag pipeline: register index, per-stage write tag,
// FSM state encoding and the tag reset value.
package pipe_pkg;

  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     rw;
    reg_idx_t rd;
    logic     load;
  } tag_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam tag_t TAG_RST = '{valid: 1'b0, rw: 1'b0, rd: 3'd0, load: 1'b0};

  // An empty ID slot becomes a bubble, so rw/load never leak from a non-instruction.
  function automatic tag_t id_tag(input logic valid, input logic rw,
                                  input reg_idx_t rd, input logic load);
    tag_t t;
    if (valid) begin
      t.valid = 1'b1;
      t.rw    = rw;
      t.rd    = rd;
      t.load  = load;
    end else begin
      t = TAG_RST;
    end
    return t;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently sitting in ID/EX.
module lu_detect
  import pipe_pkg::*;
#(
  parameter bit ZERO_REG_HARD = 1'b0
) (
  input  tag_t     idex_i,
  input  logic     id_valid_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  logic     use1_i,
  input  logic     use2_i,
  output logic     lu_o
);

  logic hit1_s;
  logic hit2_s;
  logic rd_live_s;

  // R0 cannot carry a dependency when it is hardwired, so its matches are dropped.
  always_comb begin
    hit1_s    = use1_i && (rs1_i == idex_i.rd);
    hit2_s    = use2_i && (rs2_i == idex_i.rd);
    rd_live_s = !(ZERO_REG_HARD && (idex_i.rd == 3'd0));
    lu_o      = idex_i.valid && idex_i.load && idex_i.rw && id_valid_i &&
                rd_live_s && (hit1_s || hit2_s);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Control-tag pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall insertion
// and a freeze while the memory stage waits on a slow load.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit ZERO_REG_HARD = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [2:0]       id_rd,
  input  logic             id_rw,
  input  logic             id_load,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             stall,
  output logic             freeze,
  output logic             EX_MEM_RW,
  output logic [2:0]       EX_MEM_Reg1,
  output logic             MEM_WB_RW,
  output logic [2:0]       MEM_WB_Reg1,
  output logic             ID_EX_Load,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e          state_q, state_d;
  tag_t            idex_q, idex_d;
  tag_t            exmem_q, exmem_d;
  logic            memwb_rw_q, memwb_rw_d;
  reg_idx_t        memwb_rd_q, memwb_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lu_s;
  logic            mem_wait_s;

  lu_detect #(
    .ZERO_REG_HARD(ZERO_REG_HARD)
  ) u_lu (
    .idex_i    (idex_q),
    .id_valid_i(id_valid),
    .rs1_i     (id_rs1),
    .rs2_i     (id_rs2),
    .use1_i    (id_use1),
    .use2_i    (id_use2),
    .lu_o      (lu_s)
  );

  // mem_ready only matters while EX/MEM actually holds a load.
  always_comb begin
    mem_wait_s = exmem_q.valid && exmem_q.load && !mem_ready;
  end

  // FSM, stall/freeze generation and tag advance.
  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    stall      = 1'b0;
    idex_d     = idex_q;
    exmem_d    = exmem_q;
    memwb_rw_d = memwb_rw_q;
    memwb_rd_d = memwb_rd_q;

    case (state_q)
      RUN: begin
        if (mem_wait_s) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          freeze  = 1'b0;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          freeze  = 1'b0;
          state_d = RUN;
        end else begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      default: begin
        freeze  = 1'b0;
        state_d = RUN;
      end
    endcase

    // A flushed ID slot is dead, so holding it for a load-use would waste a cycle.
    if (freeze) begin
      stall = 1'b1;
    end else begin
      stall = lu_s && !flush;
      if (lu_s || flush) begin
        idex_d = TAG_RST;
      end else begin
        idex_d = id_tag(id_valid, id_rw, id_rd, id_load);
      end
      exmem_d    = idex_q;
      memwb_rw_d = exmem_q.rw;
      memwb_rd_d = exmem_q.rd;
    end
  end

  // Saturating count of stalled or frozen cycles.
  always_comb begin
    if ((stall || freeze) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset that abandons any stall or wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      idex_q     <= TAG_RST;
      exmem_q    <= TAG_RST;
      memwb_rw_q <= 1'b0;
      memwb_rd_q <= 3'd0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      idex_q     <= idex_d;
      exmem_q    <= exmem_d;
      memwb_rw_q <= memwb_rw_d;
      memwb_rd_q <= memwb_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign EX_MEM_RW   = exmem_q.rw;
  assign EX_MEM_Reg1 = exmem_q.rd;
  assign MEM_WB_RW   = memwb_rw_q;
  assign MEM_WB_Reg1 = memwb_rd_q;
  assign ID_EX_Load  = idex_q.load;
  assign stall_cnt   = cnt_q;

endmodule
